game_ctrl: RTL

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_pkg.sv | 33 +++
 rtl/game_ctrl_key_edge.sv | 27 ++
 rtl/game_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the two-player card game controller.
// Holds the FSM state encoding, the draw key codes, the winner codes and
// the card scoring helper used by the controller.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_KEY,
    S_DRAW,
    S_LATCH,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [3:0] KEY_P1 = 4'b0011;
  localparam logic [3:0] KEY_P2 = 4'b0001;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // Points for one card: face value for 1..5, nothing for out-of-range
  // numbers, doubled when the color repeats the previously drawn card.
  function automatic logic [3:0] card_points(input logic [2:0] num,
                                             input logic [1:0] color,
                                             input logic [1:0] last_color);
    logic [3:0] base;
    base = (num >= 3'd1 && num <= 3'd5) ? {1'b0, num} : 4'd0;
    return (color == last_color) ? {base[2:0], 1'b0} : base;
  endfunction

endpackage

// File: rtl/game_ctrl_key_edge.sv
// Key event detector: one-cycle pulse when keypad_i newly matches a draw key.
// Ports: clk/rst, keypad_i (raw key code), p1_evt_o / p2_evt_o (event pulses).
// Holding a key yields a single pulse; history is cleared by reset.
module key_edge
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keypad_i,
  output logic       p1_evt_o,
  output logic       p2_evt_o
);

  logic [3:0] prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 4'b0000;
    end else begin
      prev_q <= keypad_i;
    end
  end

  assign p1_evt_o = (keypad_i == KEY_P1) && (prev_q != KEY_P1);
  assign p2_evt_o = (keypad_i == KEY_P2) && (prev_q != KEY_P2);

endmodule

// File: rtl/game_ctrl.sv
// Two-player card game controller: alternating draws, scoring, bust and
// round limits, winner decision.
// Ports: clk/rst, start, keypad_in, card_num/card_color (card datapath);
// rnd_en, whose, score1/score2, round, busy, game_over, winner.
// All outputs come from registers or are decoded from the state register.
module game_ctrl
  import game_pkg::*;
#(
  parameter int MAX_ROUNDS = 8,
  parameter int BUST_LIMIT = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] keypad_in,
  input  logic [2:0] card_num,
  input  logic [1:0] card_color,
  output logic       rnd_en,
  output logic       whose,
  output logic [7:0] score1,
  output logic [7:0] score2,
  output logic [7:0] round,
  output logic       busy,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [7:0] MAX_R  = 8'(MAX_ROUNDS);
  localparam logic [8:0] BUST_L = 9'(BUST_LIMIT);

  state_e     state_q, state_d;
  logic [7:0] score1_q, score1_d;
  logic [7:0] score2_q, score2_d;
  logic [7:0] round_q, round_d;
  logic       whose_q, whose_d;
  logic [1:0] winner_q, winner_d;
  logic [1:0] last_color_q, last_color_d;

  logic       p1_evt, p2_evt;
  logic [7:0] mover_score;
  logic [3:0] pts;
  logic [8:0] sum;
  logic [7:0] sat_score;
  logic [7:0] round_inc;
  logic       end_game;

  key_edge u_key_edge (
    .clk      (clk),
    .rst      (rst),
    .keypad_i (keypad_in),
    .p1_evt_o (p1_evt),
    .p2_evt_o (p2_evt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      score1_q     <= 8'd0;
      score2_q     <= 8'd0;
      round_q      <= 8'd0;
      whose_q      <= 1'b0;
      winner_q     <= WIN_NONE;
      last_color_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      round_q      <= round_d;
      whose_q      <= whose_d;
      winner_q     <= winner_d;
      last_color_q <= last_color_d;
    end
  end

  // Scoring arithmetic for the current mover; only consumed in LATCH/CHECK.
  assign mover_score = whose_q ? score2_q : score1_q;
  assign pts         = card_points(card_num, card_color, last_color_q);
  assign sum         = {1'b0, mover_score} + {5'b00000, pts};
  assign sat_score   = sum[8] ? 8'hFF : sum[7:0];
  assign round_inc   = round_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    round_d      = round_q;
    whose_d      = whose_q;
    winner_d     = winner_q;
    last_color_d = last_color_q;
    end_game     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          score1_d     = 8'd0;
          score2_d     = 8'd0;
          round_d      = 8'd0;
          whose_d      = 1'b0;
          winner_d     = WIN_NONE;
          last_color_d = 2'b00;
          state_d      = S_WAIT_KEY;
        end
      end
      S_WAIT_KEY: begin
        // Only the player to move may trigger a draw.
        if (whose_q ? p2_evt : p1_evt) begin
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        if (whose_q) begin
          score2_d = sat_score;
        end else begin
          score1_d = sat_score;
        end
        last_color_d = card_color;
        state_d      = S_CHECK;
      end
      S_CHECK: begin
        if ({1'b0, mover_score} > BUST_L) begin
          end_game = 1'b1;
          winner_d = whose_q ? WIN_P1 : WIN_P2;
        end else if (whose_q) begin
          round_d = round_inc;
          if (round_inc == MAX_R) begin
            end_game = 1'b1;
            if (score1_q > score2_q) begin
              winner_d = WIN_P1;
            end else if (score1_q < score2_q) begin
              winner_d = WIN_P2;
            end else begin
              winner_d = WIN_TIE;
            end
          end
        end
        if (end_game) begin
          state_d = S_DONE;
        end else begin
          whose_d = ~whose_q;
          state_d = S_WAIT_KEY;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rnd_en    = (state_q == S_DRAW);
  assign busy      = (state_q == S_WAIT_KEY) || (state_q == S_DRAW) ||
                     (state_q == S_LATCH)    || (state_q == S_CHECK);
  assign game_over = (state_q == S_DONE);
  assign whose     = whose_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign round     = round_q;
  assign winner    = winner_q;

endmodule
